camera_capture_ctrl: RTL

- Sequences capture of one camera frame (OV7670-style byte stream: VSYNC/HREF/PCLK, 8-bit data, 2 bytes per pixel) into frame memory.
- Detects frame and line boundaries and pairs consecutive bytes into 16-bit pixels (first byte = MSBs).
- Generates the write strobe and linear address for the frame buffer.
- Sits between the camera pins and the pixel memory; started by the main control FSM once per cube face.

---
 rtl/camera_capture_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl: captures one camera frame into a linear 16-bit pixel buffer
module camera_capture_ctrl #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              iniciar,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_pclk,
    input  logic [7:0]        cam_d,
    output logic [15:0]       pixel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              pronto,
    output logic              erro
);
    localparam int CW = $clog2(H_PIXELS + 1);
    localparam int LW = $clog2(V_LINES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [10:0]       r_s1, r_s2;
    logic              r_vs_q, r_hr_q, r_pc_q;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic [CW-1:0]     r_col;
    logic [LW-1:0]     r_line;
    logic [ADDR_W-1:0] r_ptr, r_base;

    logic          w_vs, w_hr, w_pc;
    logic [7:0]    w_d;
    logic          w_pc_rise, w_hr_fall, w_vs_fall, w_vs_rise;
    logic          w_cap, w_byte, w_wr, w_last;
    logic [CW-1:0] w_col_n;

    assign {w_vs, w_hr, w_pc, w_d} = r_s2;
    assign w_pc_rise = w_pc & ~r_pc_q;
    assign w_hr_fall = ~w_hr & r_hr_q;
    assign w_vs_fall = ~w_vs & r_vs_q;
    assign w_vs_rise = w_vs & ~r_vs_q;
    assign w_cap     = (r_state == S_CAP);
    // a byte coinciding with the HREF fall still belongs to the ending line
    assign w_byte    = w_cap & w_pc_rise & (w_hr | w_hr_fall);
    assign w_wr      = w_byte & r_phase & (r_col < CW'(H_PIXELS));
    assign w_col_n   = r_col + CW'(w_wr);
    assign w_last    = (r_line == LW'(V_LINES - 1));

    // two-flop synchroniser for all camera pins plus one history stage for edge detection
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_vs_q <= 1'b0;
            r_hr_q <= 1'b0;
            r_pc_q <= 1'b0;
        end else begin
            r_s1   <= {cam_vsync, cam_href, cam_pclk, cam_d};
            r_s2   <= r_s1;
            r_vs_q <= w_vs;
            r_hr_q <= w_hr;
            r_pc_q <= w_pc;
        end
    end

    // state register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next-state and status outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        pronto = 1'b0;
        case (r_state)
            S_IDLE: w_next = iniciar ? S_WAIT : S_IDLE;
            S_WAIT: begin
                busy   = 1'b1;
                w_next = w_vs_fall ? S_CAP : S_WAIT;
            end
            S_CAP: begin
                busy   = 1'b1;
                w_next = (w_vs_rise || (w_hr_fall && w_last)) ? S_DONE : S_CAP;
            end
            default: begin
                pronto = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    // byte pairing, line/column bookkeeping, write strobe and error flag
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pixel   <= '0;
            wr_en   <= 1'b0;
            addr    <= '0;
            erro    <= 1'b0;
            r_phase <= 1'b0;
            r_hi    <= '0;
            r_col   <= '0;
            r_line  <= '0;
            r_ptr   <= '0;
            r_base  <= '0;
        end else begin
            wr_en <= w_wr;
            if (r_state == S_IDLE && iniciar) erro <= 1'b0;
            if (r_state == S_WAIT && w_vs_fall) begin
                r_phase <= 1'b0;
                r_col   <= '0;
                r_line  <= '0;
                r_ptr   <= '0;
                r_base  <= '0;
            end
            if (w_cap) begin
                if (w_byte) r_phase <= ~r_phase;
                if (w_byte && !r_phase) r_hi <= w_d;
                if (w_wr) begin
                    pixel <= {r_hi, w_d};
                    addr  <= r_ptr;
                    r_ptr <= r_ptr + 1'b1;
                end
                r_col <= w_col_n;
                if (w_hr_fall) begin
                    if (w_col_n < CW'(H_PIXELS)) erro <= 1'b1;
                    r_line  <= r_line + 1'b1;
                    r_col   <= '0;
                    r_phase <= 1'b0;
                    r_base  <= r_base + ADDR_W'(H_PIXELS);
                    r_ptr   <= r_base + ADDR_W'(H_PIXELS);
                end
                if (w_vs_rise) erro <= 1'b1;
            end
        end
    end
endmodule
